// File: rtl/count_bank_sequencer.sv
// Frame-level sequencer for a bank of falling-edge pixel-class counters.
// It steers accepted pixels to a one-hot increment, freezes the bank, streams the bin counts out, then re-arms the bank.
module count_bank_sequencer #(
   parameter int NUM_BINS     = 8,
   parameter int BIN_W        = 3,
   parameter int COUNT_W      = 15,
   parameter int FRAME_PIXELS = 16384
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pixel_valid,
   input  logic [BIN_W-1:0]            pixel_class,
   output logic                        pixel_ready,
   output logic [NUM_BINS-1:0]         inc,
   output logic                        busy,
   input  logic [NUM_BINS*COUNT_W-1:0] counts_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BIN_W-1:0]            out_bin,
   output logic [COUNT_W-1:0]          out_data,
   output logic                        out_last,
   output logic                        frame_done,
   output logic                        class_err
);

   localparam int                PIX_W    = $clog2(FRAME_PIXELS + 1);
   localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(FRAME_PIXELS - 1);
   localparam logic [BIN_W-1:0]  BIN_LAST = BIN_W'(NUM_BINS - 1);

   typedef enum logic [1:0] {
      ST_COUNT,
      ST_SETTLE,
      ST_READ,
      ST_WAIT
   } state_e;

   state_e              state_q, state_d;
   logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
   logic [BIN_W-1:0]    rd_idx_q, rd_idx_d;
   logic [NUM_BINS-1:0] inc_q, inc_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                class_err_q, class_err_d;

   logic                accept;
   logic                class_ok;
   logic [31:0]         class_ext;

   assign pixel_ready = (state_q == ST_COUNT) || (state_q == ST_WAIT);
   assign accept      = pixel_valid && pixel_ready;
   assign class_ext   = 32'(pixel_class);
   assign class_ok    = class_ext < 32'(NUM_BINS);

   assign inc        = inc_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign class_err  = class_err_q;
   assign out_valid  = (state_q == ST_READ);
   assign out_bin    = rd_idx_q;
   assign out_last   = out_valid && (rd_idx_q == BIN_LAST);

   // The bank is frozen during readout, so the selected slice is stable under backpressure.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < NUM_BINS; i++) begin
         if (rd_idx_q == BIN_W'(i)) out_data = counts_in[i*COUNT_W +: COUNT_W];
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      rd_idx_d     = rd_idx_q;
      inc_d        = '0;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      class_err_d  = class_err_q | (accept && !class_ok);

      if (accept) begin
         for (int i = 0; i < NUM_BINS; i++) inc_d[i] = (class_ext == 32'(i));
      end

      case (state_q)
         ST_COUNT: begin
            busy_d = 1'b0;
            if (accept) begin
               if (pix_cnt_q == PIX_LAST) begin
                  state_d   = ST_SETTLE;
                  pix_cnt_d = '0;
               end else begin
                  pix_cnt_d = pix_cnt_q + PIX_W'(1);
               end
            end
         end
         ST_SETTLE: begin
            busy_d  = 1'b1;
            state_d = ST_READ;
         end
         ST_READ: begin
            busy_d = 1'b1;
            if (out_ready) begin
               if (out_last) begin
                  state_d      = ST_WAIT;
                  rd_idx_d     = '0;
                  frame_done_d = 1'b1;
               end else begin
                  rd_idx_d = rd_idx_q + BIN_W'(1);
               end
            end
         end
         ST_WAIT: begin
            busy_d = 1'b1;
            // Dropping busy together with the first increment makes the bank reload instead of accumulate.
            if (accept) begin
               busy_d = 1'b0;
               if (FRAME_PIXELS == 1) begin
                  state_d   = ST_SETTLE;
                  pix_cnt_d = '0;
               end else begin
                  state_d   = ST_COUNT;
                  pix_cnt_d = PIX_W'(1);
               end
            end
         end
         default: state_d = ST_COUNT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_COUNT;
         pix_cnt_q    <= '0;
         rd_idx_q     <= '0;
         inc_q        <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         class_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         rd_idx_q     <= rd_idx_d;
         inc_q        <= inc_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         class_err_q  <= class_err_d;
      end
   end

endmodule

// File: doc/count_bank_sequencer.md
Name: count_bank_sequencer

Overview:
- Frame-level controller for a bank of NUM_BINS pixel-class counters. Each counter adds its 1-bit increment on the falling clock edge, holds its value while busy is high, and reloads from its increment on the first non-busy edge after busy.
- The sequencer accepts classified pixels and steers each one to a one-hot increment. After FRAME_PIXELS pixels it freezes the bank with busy and streams every bin count out over a valid/ready port.
- It then restarts the bank so that the first pixel of the next frame reloads the counters cleanly. It sits between the pixel classifier and the sort/rank stage.

Parameters:
- NUM_BINS, 8, number of counters and classes; must be 2..64.
- BIN_W, 3, width of pixel_class and out_bin; must satisfy 2^BIN_W >= NUM_BINS.
- COUNT_W, 15, width of each counter value.
- FRAME_PIXELS, 16384, pixels per frame; must be 1..2^COUNT_W-1.

Ports:
- clk  input  1  clock; this block uses the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- pixel_valid  input  1  pixel_class is valid this cycle.
- pixel_class  input  BIN_W  class index of the pixel.
- pixel_ready  output  1  sequencer accepts a pixel this cycle.
- inc  output  NUM_BINS  one-hot increment, one bit per counter "in" input.
- busy  output  1  freeze/reload control, shared by all counters.
- counts_in  input  NUM_BINS*COUNT_W  flattened counter outputs; bin j occupies bits [j*COUNT_W +: COUNT_W].
- out_valid  output  1  readout word valid.
- out_ready  input  1  downstream accepts the readout word.
- out_bin  output  BIN_W  bin index of the current word.
- out_data  output  COUNT_W  count of bin out_bin.
- out_last  output  1  high with the word for bin NUM_BINS-1.
- frame_done  output  1  one-cycle pulse after the last word is accepted.
- class_err  output  1  sticky flag: a pixel with class >= NUM_BINS was accepted.

Behaviour:
- Reset values: state=COUNT, pix_cnt=0, rd_idx=0, inc=0, busy=0, out_valid=0, frame_done=0, class_err=0.
- Pixel acceptance: a pixel is accepted when pixel_valid && pixel_ready. pixel_ready=1 only in the COUNT and WAIT states.
- inc and busy are registered on the rising edge. On the cycle after an acceptance, inc[pixel_class]=1; otherwise inc=0. The counters therefore sample a stable value on the following falling edge.
- Out-of-range class (pixel_class >= NUM_BINS): inc stays all-zero, the pixel is still counted toward FRAME_PIXELS, and class_err is set. class_err clears only on reset.
- COUNT state, busy=0:
  - Each accepted pixel increments pix_cnt.
  - An acceptance with pix_cnt==FRAME_PIXELS-1 moves to SETTLE and clears pix_cnt.
- SETTLE (1 cycle): busy=0. The last pixel's inc is presented this cycle. Next state is READ, with busy going to 1 on the same edge.
- READ state, busy=1, inc=0:
  - out_valid=1, out_bin=rd_idx, out_data=counts_in slice rd_idx (combinational mux), out_last=(rd_idx==NUM_BINS-1).
  - On out_ready, rd_idx advances. On out_ready with out_last, go to WAIT, reset rd_idx to 0, and pulse frame_done in the next cycle.
  - out_bin and out_data are stable while out_valid && !out_ready.
- WAIT state, busy=1: busy stays high so the counters hold the previous frame's totals.
  - The first accepted pixel registers busy=0 and inc for that pixel on the same edge. The counters reload to that increment, so a new frame starts with the correct count (the target bin is 1, all others 0).
  - pix_cnt becomes 1 and the next state is COUNT. If FRAME_PIXELS==1, the next state is SETTLE instead.
- Idle stretches: idle cycles in COUNT or WAIT change nothing.
- First frame: the first frame after reset counts from the counters' own reset value of 0.
- Asynchronous reset mid-frame or mid-readout: all outputs and state return to reset values immediately, and a partial readout is abandoned. The counter bank shares rst, so the first frame restarts from zero.
- Arithmetic: pix_cnt is an unsigned counter of width clog2(FRAME_PIXELS+1) and never wraps. rd_idx has width BIN_W.

Test Plan (NUM_BINS=4, BIN_W=2, COUNT_W=15, FRAME_PIXELS=8, bank modelled with negedge counters):
- Reset then 8 pixels with classes 0,1,1,2,3,3,3,0 and out_ready=1 → SETTLE, then busy=1. Readout words (bin,data) are (0,2),(1,2),(2,1),(3,3), out_last is high on bin 3, frame_done pulses once, and pixel_ready=0 throughout READ.
- Backpressure: same frame, with out_ready held low for 5 cycles on bin 1 → out_bin=1 and out_data=2 stay stable, with no skipped or duplicated words.
- Frame 2 starts with one pixel of class 2, followed by 7 pixels of class 0 → busy falls with inc=0100, and the readout is (0,7),(1,0),(2,1),(3,0), proving reload rather than accumulation.
- One class-5 pixel (via BIN_W=3, NUM_BINS=4) among 8 pixels → inc=0 that cycle, class_err=1 and stays 1, and the word totals sum to 7.
- rst asserted during READ at bin 2 → out_valid=0, busy=0, and state=COUNT immediately. A following frame of 8 class-1 pixels reads (1,8) with all other bins 0.
- FRAME_PIXELS=1 with pixels of class 3 in consecutive frames → each frame yields (3,1) with all other bins 0.
